// File: rtl/goertzel_frame_ctrl.sv
// goertzel_frame_ctrl
//   Sequences one goertzel_IIR engine over back-to-back N-sample frames:
//   clears the engine, paces its sample clock-enable (one pulse every DIV
//   clocks), waits for the frame result and packs it into a 128-bit
//   AXI4-Stream word tagged with frame id and drop count.
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_enable          1 = run frames continuously, 0 = stop/abort
//   o_gz_clken        engine sample clock-enable
//   o_gz_rst          engine clear (active high)
//   i_gz_tdata/tvalid engine result {re[OW], im[OW]} and its valid
//   m_axis_*          packed result stream toward the PS
//   o_busy            controller not idle
//   o_drop_cnt        results lost to back-pressure (saturating)
//   o_err_cnt         frames that timed out waiting for a result (saturating)
module goertzel_frame_ctrl #(
  parameter int unsigned N       = 126,
  parameter int unsigned DIV     = 2,
  parameter int unsigned OW      = 20,
  parameter int unsigned SAW     = 16,
  parameter int unsigned CLR_CYC = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  output logic              o_gz_clken,
  output logic              o_gz_rst,
  input  logic [2*OW-1:0]   i_gz_tdata,
  input  logic              i_gz_tvalid,
  output logic [127:0]      m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              o_busy,
  output logic [CW-1:0]     o_drop_cnt,
  output logic [CW-1:0]     o_err_cnt
);

  localparam int unsigned DW  = $clog2(DIV + 1);
  localparam int unsigned SW  = $clog2(N + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned CCW = $clog2(CLR_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   smp_cnt;
  logic [TW-1:0]   to_cnt;
  logic [CCW-1:0]  clr_cnt;
  logic [CW-1:0]   frame_id;
  logic            tick;
  logic            capture;
  logic            timeout;
  logic            pacing;
  logic [127:0]    word;

  // The sample cadence keeps running through WAIT so the engine can flush.
  assign pacing = (state == S_RUN) || (state == S_WAIT);
  assign tick   = pacing && (div_cnt == DW'(DIV - 1));

  assign word = {32'(frame_id), 32'(o_drop_cnt), 32'h0,
                 i_gz_tdata[2*OW-1 -: SAW], i_gz_tdata[OW-1 -: SAW]};

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    timeout    = 1'b0;
    o_gz_clken = tick;
    o_gz_rst   = (state == S_IDLE) || (state == S_CLEAR);
    o_busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (i_enable) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (!i_enable)                              state_nxt = S_IDLE;
        else if (clr_cnt == CCW'(CLR_CYC - 1))      state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_enable)                              state_nxt = S_IDLE;
        else if (tick && (smp_cnt == SW'(N - 1)))   state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Abort has priority over a result or timeout arriving this cycle.
        if (!i_enable) begin
          state_nxt = S_IDLE;
        end else if (i_gz_tvalid) begin
          capture   = 1'b1;
          state_nxt = S_CLEAR;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      smp_cnt       <= '0;
      to_cnt        <= '0;
      clr_cnt       <= '0;
      frame_id      <= '0;
      o_drop_cnt    <= '0;
      o_err_cnt     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state <= state_nxt;

      clr_cnt <= (state == S_CLEAR && state_nxt == S_CLEAR) ? clr_cnt + 1'b1 : '0;
      to_cnt  <= (state == S_WAIT  && state_nxt == S_WAIT)  ? to_cnt + 1'b1  : '0;

      if (state_nxt != S_RUN)
        smp_cnt <= '0;
      else if (state == S_RUN && tick)
        smp_cnt <= smp_cnt + 1'b1;

      // Divider is zeroed on RUN entry but carries over from RUN into WAIT.
      if (pacing && (state_nxt == S_RUN || state_nxt == S_WAIT))
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (capture || timeout)
        frame_id <= frame_id + 1'b1;

      if (timeout && (o_err_cnt != '1))
        o_err_cnt <= o_err_cnt + 1'b1;

      if (capture && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= word;
        m_axis_tvalid <= 1'b1;
      end else begin
        if (capture && (o_drop_cnt != '1))
          o_drop_cnt <= o_drop_cnt + 1'b1;
        if (m_axis_tvalid && m_axis_tready)
          m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Testbench for goertzel_frame_ctrl (N=4, DIV=2, CLR_CYC=2, TIMEOUT=8).
module tb_goertzel_frame_ctrl;

  localparam int N   = 4;
  localparam int DIV = 2;
  localparam int OW  = 20;
  localparam int CLR = 2;
  localparam int TO  = 8;
  localparam int CW  = 32;
  localparam int WAIT0 = CLR + N*DIV;  // frame offset at which result wait begins

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           gz_clken, gz_rst;
  logic [2*OW-1:0] gz_tdata = '0;
  logic           gz_tvalid = 1'b0;
  logic [127:0]   tdata;
  logic           tvalid;
  logic           tready = 1'b0;
  logic           busy;
  logic [CW-1:0]  drop_cnt, err_cnt;

  goertzel_frame_ctrl #(
    .N(N), .DIV(DIV), .OW(OW), .SAW(16), .CLR_CYC(CLR), .TIMEOUT(TO), .CW(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_gz_clken(gz_clken), .o_gz_rst(gz_rst),
    .i_gz_tdata(gz_tdata), .i_gz_tvalid(gz_tvalid),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .o_busy(busy), .o_drop_cnt(drop_cnt), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t counts cycles since the frame's clear began:
  //   [0, CLR)          engine held in clear
  //   [CLR, WAIT0)      N samples, one every DIV cycles
  //   [WAIT0, ...)      waiting for the result, gives up after TO cycles
  bit           m_act;
  int           m_t;
  logic [31:0]  m_id, m_drop, m_err;
  bit           m_bv;
  logic [127:0] m_buf;
  logic [127:0] m_word;
  bit           m_cap;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_id = 0; m_drop = 0; m_err = 0; m_bv = 0; m_buf = '0;
    end else begin
      m_cap  = 0;
      m_word = {m_id, m_drop, 32'h0, gz_tdata[39:24], gz_tdata[19:4]};
      if (!m_act) begin
        if (en) begin m_act = 1; m_t = 0; end
      end else if (!en) begin
        m_act = 0;
      end else if (m_t >= WAIT0 && gz_tvalid) begin
        m_cap = 1; m_id++; m_t = 0;
      end else if (m_t == WAIT0 + TO - 1) begin
        if (m_err != '1) m_err++;
        m_id++; m_t = 0;
      end else begin
        m_t++;
      end
      if (m_cap) begin
        if (!m_bv || tready) begin m_buf = m_word; m_bv = 1; end
        else if (m_drop != '1) m_drop++;
      end else if (m_bv && tready) begin
        m_bv = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    chk("gz_rst",   gz_rst,   (!m_act || m_t < CLR));
    chk("gz_clken", gz_clken, (m_act && m_t >= CLR && ((m_t - CLR + 1) % DIV == 0)));
    chk("busy",     busy,     m_act);
    chk("tvalid",   tvalid,   m_bv);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("err_cnt",  err_cnt,  m_err);
    if (m_bv) chk("tdata", tdata, m_buf);
  end

  // Engine stand-in: answers 2 cycles into the wait, data tagged by frame id.
  bit rnd_mode = 1;
  bit eng_on = 1;
  initial forever begin
    @(negedge clk);
    if (rnd_mode) begin
      gz_tvalid = 1'($urandom());
      gz_tdata  = 40'({$urandom(), $urandom()});
    end else begin
      gz_tvalid = eng_on && m_act && (m_t == WAIT0 + 2);
      gz_tdata  = 40'hABCD0_12340 ^ {m_id[7:0], 12'h0, m_id[7:0], 12'h0};
    end
  end

  // ---------------- stimulus ----------------
  int cur;
  task automatic to_cyc(input int k);
    while (cur < k) begin @(negedge clk); cur++; end
  endtask

  task automatic wait_id(input logic [31:0] id, input string name);
    int k = 0;
    while (m_id != id && k < 300) begin @(negedge clk); k++; end
    if (m_id != id) chk({name, "_timeout"}, m_id, id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with random inputs, then release with enable low
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en = 1'($urandom()); tready = 1'($urandom());
      #1;
      chk("rst_gz_rst", gz_rst, 1);
      chk("rst_clken",  gz_clken, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata",  tdata, 0);
      chk("rst_busy",   busy, 0);
      chk("rst_cnts",   {drop_cnt, err_cnt}, 0);
    end
    @(negedge clk);
    en = 0; tready = 0; rnd_mode = 0;
    #2 rst_n = 1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rst",  gz_rst, 1);

    // 2: first frame timeline, result at cycle 13
    en = 1; cur = 0;
    to_cyc(1);  chk("t2_busy_c1", busy, 1); chk("t2_rst_c1", gz_rst, 1);
    to_cyc(2);  chk("t2_rst_c2", gz_rst, 1);
    to_cyc(3);  chk("t2_rst_c3", gz_rst, 0); chk("t2_clken_c3", gz_clken, 0);
    to_cyc(4);  chk("t2_clken_c4", gz_clken, 1);
    to_cyc(5);  chk("t2_clken_c5", gz_clken, 0);
    to_cyc(10); chk("t2_clken_c10", gz_clken, 1);
    to_cyc(13); chk("t2_tvalid_c13", tvalid, 0);
    to_cyc(14);
    chk("t2_tvalid_c14", tvalid, 1);
    chk("t2_lo",  tdata[31:0], 32'hABCD_1234);
    chk("t2_id",  tdata[127:96], 0);
    chk("t2_rst_c14", gz_rst, 1);

    // 3: back-pressure over frames 1 and 2
    wait_id(3, "t3_frames");
    chk("t3_held_id", tdata[127:96], 0);
    chk("t3_held_lo", tdata[31:0], 32'hABCD_1234);
    chk("t3_drop", drop_cnt, 2);
    tready = 1;
    @(negedge clk);
    chk("t3_consumed", tvalid, 0);
    wait_id(4, "t3_next");
    chk("t3_next_valid", tvalid, 1);
    chk("t3_next_id",   tdata[127:96], 3);
    chk("t3_next_drop", tdata[95:64], 2);
    chk("t3_next_lo",   tdata[31:0], 32'hA8CD_1134);

    // 4: timeout with silent engine, after a fresh reset
    @(negedge clk);
    #2 rst_n = 0;
    en = 0; eng_on = 0; tready = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    en = 1; cur = 0;
    to_cyc(18); chk("t4_err_c18", err_cnt, 0); chk("t4_rst_c18", gz_rst, 0);
    to_cyc(19); chk("t4_err_c19", err_cnt, 1); chk("t4_rst_c19", gz_rst, 1);
    chk("t4_no_word", tvalid, 0);
    eng_on = 1;
    wait_id(2, "t4_next");
    chk("t4_valid", tvalid, 1);
    chk("t4_id", tdata[127:96], 1);

    // 5: abort in RUN after two samples, id must not advance
    en = 0;
    repeat (3) @(negedge clk);
    chk("t5_idle", busy, 0);
    en = 1; cur = 0;
    to_cyc(6); chk("t5_clken_c6", gz_clken, 1);
    to_cyc(7); en = 0;
    to_cyc(8);
    chk("t5_busy", busy, 0); chk("t5_rst", gz_rst, 1); chk("t5_clken", gz_clken, 0);
    repeat (4) @(negedge clk);
    chk("t5_no_word", tvalid, 0);
    en = 1;
    wait_id(3, "t5_next");
    chk("t5_id", tdata[127:96], 2);

    // 6: async reset while waiting with a word pending
    tready = 0;
    wait_id(4, "t6_frame");
    chk("t6_pending", tvalid, 1);
    eng_on = 0;
    begin
      int k = 0;
      while (m_t < WAIT0 + 1 && k < 100) begin @(negedge clk); k++; end
    end
    chk("t6_in_wait", gz_rst, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_tvalid", tvalid, 0);
    chk("t6_tdata",  tdata, 0);
    chk("t6_err",    err_cnt, 0);
    chk("t6_busy",   busy, 0);
    chk("t6_rst",    gz_rst, 1);
    en = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t6_after_tvalid", tvalid, 0);
    chk("t6_after_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
